// File: rtl/rv32_issue_ctrl_pkg.sv
// Shared definitions for the rv32 issue/hazard controller.
package rv32_issue_ctrl_pkg;

  localparam int unsigned API_DATA_WIDTH          = 32;
  localparam int unsigned API_REGISTER_ADDR_WIDTH = 5;
  localparam int unsigned ISSUE_NREG              = 32;
  localparam int unsigned ISSUE_STATE_WIDTH       = 2;

  typedef enum logic [ISSUE_STATE_WIDTH-1:0] {
    ISSUE_RUN     = 2'd0,
    ISSUE_WAIT_BR = 2'd1,
    ISSUE_FLUSH   = 2'd2
  } issue_state_e;

endpackage

// File: rtl/rv32_issue_ctrl_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A set and a clear of the same register in one cycle leave the bit set;
// x0 is never marked busy.
module rv32_scoreboard
  import rv32_issue_ctrl_pkg::*;
#(
  parameter int unsigned RA_W = API_REGISTER_ADDR_WIDTH,
  parameter int unsigned NREG = ISSUE_NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en_i,
  input  logic [RA_W-1:0] set_addr_i,
  input  logic            clr_en_i,
  input  logic [RA_W-1:0] clr_addr_i,
  input  logic [RA_W-1:0] rd_addr0_i,
  input  logic [RA_W-1:0] rd_addr1_i,
  input  logic [RA_W-1:0] rd_addr2_i,
  output logic            busy0_o,
  output logic            busy1_o,
  output logic            busy2_o,
  output logic [NREG-1:0] bitmap_o
);

  logic [NREG-1:0] bitmap_q;
  logic [NREG-1:0] bitmap_d;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Next bitmap: clear first, then set, so a same-cycle set wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en_i) set_mask[set_addr_i] = 1'b1;
    if (clr_en_i) clr_mask[clr_addr_i] = 1'b1;
    bitmap_d    = (bitmap_q & ~clr_mask) | set_mask;
    bitmap_d[0] = 1'b0;
  end

  // Bitmap register.
  always_ff @(posedge clk) begin
    if (rst) bitmap_q <= '0;
    else     bitmap_q <= bitmap_d;
  end

  assign busy0_o  = (rd_addr0_i != '0) && bitmap_q[rd_addr0_i];
  assign busy1_o  = (rd_addr1_i != '0) && bitmap_q[rd_addr1_i];
  assign busy2_o  = (rd_addr2_i != '0) && bitmap_q[rd_addr2_i];
  assign bitmap_o = bitmap_q;

endmodule

// File: rtl/rv32_issue_ctrl.sv
// Issue/hazard controller: one-entry decode slot, scoreboard hazard check,
// valid/ready issue to execute, and branch serialisation with squash.
module rv32_issue_ctrl
  import rv32_issue_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = API_DATA_WIDTH,
  parameter int unsigned RA_W = API_REGISTER_ADDR_WIDTH,
  parameter int unsigned NREG = ISSUE_NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [XLEN-1:0] if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic [XLEN-1:0] dec_instr_o,
  input  logic [RA_W-1:0] dec_rs1_i,
  input  logic [RA_W-1:0] dec_rs2_i,
  input  logic [RA_W-1:0] dec_rd_i,
  input  logic            dec_reg_w_i,
  input  logic            dec_is_branch_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] ex_pc_o,
  input  logic            wb_valid_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic            br_resolve_i,
  input  logic            br_taken_i,
  output logic            flush_o,
  output logic            stall_o,
  output logic [NREG-1:0] pending_o
);

  issue_state_e    state_q;
  logic            slot_valid_q;
  logic [XLEN-1:0] slot_instr_q;
  logic [XLEN-1:0] slot_pc_q;
  logic            flush_q;

  logic busy_rs1, busy_rs2, busy_rd;
  logic hz, run, fire, accept;

  rv32_scoreboard #(
    .RA_W (RA_W),
    .NREG (NREG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (fire & dec_reg_w_i),
    .set_addr_i (dec_rd_i),
    .clr_en_i   (wb_valid_i),
    .clr_addr_i (wb_rd_i),
    .rd_addr0_i (dec_rs1_i),
    .rd_addr1_i (dec_rs2_i),
    .rd_addr2_i (dec_rd_i),
    .busy0_o    (busy_rs1),
    .busy1_o    (busy_rs2),
    .busy2_o    (busy_rd),
    .bitmap_o   (pending_o)
  );

  // Hazard/handshake terms; the registered bitmap is used, so a writeback
  // releases a dependent instruction one cycle later.
  always_comb begin
    run    = (state_q == ISSUE_RUN);
    hz     = slot_valid_q & (busy_rs1 | busy_rs2 | (dec_reg_w_i & busy_rd));
    fire   = run & slot_valid_q & ~hz & ex_ready_i;
    accept = if_valid_i & run & (~slot_valid_q | fire);
  end

  // Control FSM plus slot register; a taken branch empties the slot on
  // entry to FLUSH so the squashed instruction is never presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ISSUE_RUN;
      slot_valid_q <= 1'b0;
      slot_instr_q <= '0;
      slot_pc_q    <= '0;
      flush_q      <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      unique case (state_q)
        ISSUE_RUN: begin
          if (accept) begin
            slot_valid_q <= 1'b1;
            slot_instr_q <= if_instr_i;
            slot_pc_q    <= if_pc_i;
          end else if (fire) begin
            slot_valid_q <= 1'b0;
          end
          if (fire && dec_is_branch_i) state_q <= ISSUE_WAIT_BR;
        end
        ISSUE_WAIT_BR: begin
          if (br_resolve_i) begin
            if (br_taken_i) begin
              state_q      <= ISSUE_FLUSH;
              flush_q      <= 1'b1;
              slot_valid_q <= 1'b0;
            end else begin
              state_q <= ISSUE_RUN;
            end
          end
        end
        ISSUE_FLUSH: begin
          slot_valid_q <= 1'b0;
          state_q      <= ISSUE_RUN;
        end
        default: state_q <= ISSUE_RUN;
      endcase
    end
  end

  assign if_ready_o  = run & (~slot_valid_q | fire);
  assign ex_valid_o  = run & slot_valid_q & ~hz;
  assign stall_o     = run & slot_valid_q & hz;
  assign dec_instr_o = slot_valid_q ? slot_instr_q : '0;
  assign ex_pc_o     = slot_pc_q;
  assign flush_o     = flush_q;

endmodule

// File: tb/tb_rv32_issue_ctrl.sv
// Directed bench for rv32_issue_ctrl with a small behavioural rv32 decoder.
module tb_rv32_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] dec_instr;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_reg_w, dec_is_branch;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        br_resolve, br_taken;
  logic        flush, stall;
  logic [31:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32_issue_ctrl #(
    .XLEN (32),
    .RA_W (5),
    .NREG (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .if_valid_i      (if_valid),
    .if_ready_o      (if_ready),
    .if_instr_i      (if_instr),
    .if_pc_i         (if_pc),
    .dec_instr_o     (dec_instr),
    .dec_rs1_i       (dec_rs1),
    .dec_rs2_i       (dec_rs2),
    .dec_rd_i        (dec_rd),
    .dec_reg_w_i     (dec_reg_w),
    .dec_is_branch_i (dec_is_branch),
    .ex_valid_o      (ex_valid),
    .ex_ready_i      (ex_ready),
    .ex_pc_o         (ex_pc),
    .wb_valid_i      (wb_valid),
    .wb_rd_i         (wb_rd),
    .br_resolve_i    (br_resolve),
    .br_taken_i      (br_taken),
    .flush_o         (flush),
    .stall_o         (stall),
    .pending_o       (pending)
  );

  // Minimal decoder: OP, OP-IMM and BRANCH; anything else decodes to nothing.
  always_comb begin
    dec_rs1       = '0;
    dec_rs2       = '0;
    dec_rd        = '0;
    dec_reg_w     = 1'b0;
    dec_is_branch = 1'b0;
    case (dec_instr[6:0])
      7'b0110011: begin
        dec_rs1 = dec_instr[19:15]; dec_rs2 = dec_instr[24:20];
        dec_rd  = dec_instr[11:7];  dec_reg_w = 1'b1;
      end
      7'b0010011: begin
        dec_rs1 = dec_instr[19:15]; dec_rd = dec_instr[11:7]; dec_reg_w = 1'b1;
      end
      7'b1100011: begin
        dec_rs1 = dec_instr[19:15]; dec_rs2 = dec_instr[24:20]; dec_is_branch = 1'b1;
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, 5'b0, 7'b1100011};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic wb_one(input logic [4:0] rd);
    wb_valid = 1'b1;
    wb_rd    = rd;
    tick();
    wb_valid = 1'b0;
    wb_rd    = '0;
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; ex_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; br_resolve = 1'b0; br_taken = 1'b0;
    tick(); tick();

    // Reset state
    @(negedge clk);
    check("rst_if_ready", 32'(if_ready), 32'd1);
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_flush",    32'(flush),    32'd0);
    check("rst_stall",    32'(stall),    32'd0);
    check("rst_pending",  pending,       32'h0);
    check("rst_dec",      dec_instr,     32'h0);
    check("rst_ex_pc",    ex_pc,         32'h0);

    // First instruction: accepted at N, issued at N+1
    tick();
    rst = 1'b0; ex_ready = 1'b1;
    offer(enc_add(5'd1, 5'd2, 5'd3), 32'h100);
    @(negedge clk);
    check("n0_ex_valid", 32'(ex_valid), 32'd0);
    check("n0_if_ready", 32'(if_ready), 32'd1);
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    check("n1_ex_valid", 32'(ex_valid), 32'd1);
    check("n1_ex_pc",    ex_pc,         32'h100);
    check("n1_dec",      dec_instr,     enc_add(5'd1, 5'd2, 5'd3));
    tick();
    @(negedge clk);
    check("n2_pending",  pending,       32'h0000_0002);
    check("n2_ex_valid", 32'(ex_valid), 32'd0);
    wb_one(5'd1);
    @(negedge clk);
    check("wb1_pending", pending, 32'h0);

    // RAW hazard: ADD x5 then ADD x6,x5,x5 back to back
    offer(enc_add(5'd5, 5'd1, 5'd2), 32'h104);
    tick();
    offer(enc_add(5'd6, 5'd5, 5'd5), 32'h108);
    tick();
    if_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("raw_stall",    32'(stall),    32'd1);
      check("raw_ex_valid", 32'(ex_valid), 32'd0);
      tick();
    end
    wb_valid = 1'b1; wb_rd = 5'd5;
    @(negedge clk);
    check("raw_wb_cycle_stall", 32'(stall), 32'd1);
    tick();
    wb_valid = 1'b0; wb_rd = '0;
    @(negedge clk);
    check("raw_rel_stall",    32'(stall),    32'd0);
    check("raw_rel_ex_valid", 32'(ex_valid), 32'd1);
    check("raw_rel_ex_pc",    ex_pc,         32'h108);
    tick();
    @(negedge clk);
    check("raw_pending", pending, 32'h0000_0040);

    // Set/clear collision on x7, then x0 never becomes busy
    offer(enc_addi(5'd7, 5'd0, 12'd1), 32'h10C);
    tick();
    if_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd7;
    @(negedge clk);
    check("col_ex_valid", 32'(ex_valid), 32'd1);
    tick();
    wb_valid = 1'b0; wb_rd = '0;
    @(negedge clk);
    check("col_pending", pending, 32'h0000_00C0);
    offer(enc_addi(5'd0, 5'd0, 12'd0), 32'h110);
    tick();
    if_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd0;
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    check("x0_pending", pending, 32'h0000_00C0);
    wb_one(5'd6);
    wb_one(5'd7);
    @(negedge clk);
    check("clr_pending", pending, 32'h0);

    // Backpressure with a full slot and fetch still offering
    ex_ready = 1'b0;
    offer(enc_add(5'd8, 5'd0, 5'd0), 32'h200);
    tick();
    offer(enc_add(5'd9, 5'd0, 5'd0), 32'h204);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ex_valid", 32'(ex_valid), 32'd1);
      check("bp_ex_pc",    ex_pc,         32'h200);
      check("bp_if_ready", 32'(if_ready), 32'd0);
      tick();
    end
    ex_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_if_ready", 32'(if_ready), 32'd1);
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    check("bp_refill_pc",    ex_pc,         32'h204);
    check("bp_refill_valid", 32'(ex_valid), 32'd1);
    check("bp_pending8",     pending,       32'h0000_0100);
    tick();
    @(negedge clk);
    check("bp_pending89", pending, 32'h0000_0300);
    wb_one(5'd8);
    wb_one(5'd9);

    // Resolve outside WAIT_BR is ignored
    br_resolve = 1'b1; br_taken = 1'b1;
    tick();
    br_resolve = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    check("idle_resolve_flush",    32'(flush),    32'd0);
    check("idle_resolve_if_ready", 32'(if_ready), 32'd1);

    // Taken branch with the next instruction already in the slot
    offer(enc_beq(5'd0, 5'd0), 32'h300);
    tick();
    offer(enc_add(5'd10, 5'd0, 5'd0), 32'h304);
    @(negedge clk);
    check("tb_beq_valid", 32'(ex_valid), 32'd1);
    tick();
    if_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("tb_wait_ex_valid", 32'(ex_valid), 32'd0);
      check("tb_wait_if_ready", 32'(if_ready), 32'd0);
      check("tb_wait_flush",    32'(flush),    32'd0);
      tick();
    end
    br_resolve = 1'b1; br_taken = 1'b1;
    @(negedge clk);
    check("tb_res_ex_valid", 32'(ex_valid), 32'd0);
    tick();
    br_resolve = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    check("tb_flush",          32'(flush),    32'd1);
    check("tb_flush_if_ready", 32'(if_ready), 32'd0);
    check("tb_flush_ex_valid", 32'(ex_valid), 32'd0);
    check("tb_flush_dec",      dec_instr,     32'h0);
    tick();
    @(negedge clk);
    check("tb_post_flush",    32'(flush),    32'd0);
    check("tb_post_if_ready", 32'(if_ready), 32'd1);
    check("tb_post_ex_valid", 32'(ex_valid), 32'd0);
    check("tb_post_pending",  pending,       32'h0);

    // Not-taken branch: slot instruction issues right after resolve
    offer(enc_beq(5'd0, 5'd0), 32'h400);
    tick();
    offer(enc_add(5'd11, 5'd0, 5'd0), 32'h404);
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    check("nt_wait_ex_valid", 32'(ex_valid), 32'd0);
    br_resolve = 1'b1; br_taken = 1'b0;
    tick();
    br_resolve = 1'b0;
    @(negedge clk);
    check("nt_ex_valid", 32'(ex_valid), 32'd1);
    check("nt_ex_pc",    ex_pc,         32'h404);
    check("nt_flush",    32'(flush),    32'd0);
    tick();
    @(negedge clk);
    check("nt_pending", pending, 32'h0000_0800);

    // Reset while waiting on a branch
    offer(enc_beq(5'd0, 5'd0), 32'h500);
    tick();
    if_valid = 1'b0;
    tick();
    @(negedge clk);
    check("rwb_if_ready", 32'(if_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rwb_pending",  pending,       32'h0);
    check("rwb_flush",    32'(flush),    32'd0);
    check("rwb_if_ready", 32'(if_ready), 32'd1);
    check("rwb_ex_valid", 32'(ex_valid), 32'd0);
    check("rwb_dec",      dec_instr,     32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_issue_ctrl.md
Name: rv32_issue_ctrl

Overview:
- Issue/hazard controller between instruction fetch and the execution unit.
- Holds one fetched instruction in a decode slot and drives it into the rv32im decoder.
- Checks the decoder's register addresses against a pending-write scoreboard and issues to execute with a valid/ready handshake.
- Serialises control flow: no issue past an unresolved branch/jump; squashes the slot on a taken branch.

Parameters:
XLEN, 32 (`API_DATA_WIDTH), instruction/PC width
RA_W, 5 (`API_REGISTER_ADDR_WIDTH), register address width
NREG, 32, architectural register count (scoreboard bits)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
if_valid_i  in  1  fetch offers instruction
if_ready_o  out  1  slot can accept (combinational)
if_instr_i  in  XLEN  fetched instruction
if_pc_i  in  XLEN  PC of fetched instruction
dec_instr_o  out  XLEN  slot instruction to decoder (0 when slot empty)
dec_rs1_i  in  RA_W  decoder rs1 (0 = unused)
dec_rs2_i  in  RA_W  decoder rs2 (0 = unused)
dec_rd_i  in  RA_W  decoder rd
dec_reg_w_i  in  1  decoder register-write flag
dec_is_branch_i  in  1  decoder branch/jump flag (JAL, JALR, Bxx)
ex_valid_o  out  1  instruction issued this cycle
ex_ready_i  in  1  execute accepts
ex_pc_o  out  XLEN  PC of slot instruction
wb_valid_i  in  1  writeback retiring a register write
wb_rd_i  in  RA_W  writeback destination
br_resolve_i  in  1  branch unit resolved the outstanding branch
br_taken_i  in  1  resolved branch taken (qualified by br_resolve_i)
flush_o  out  1  one-cycle squash pulse to fetch
stall_o  out  1  slot blocked by a hazard
pending_o  out  NREG  scoreboard bitmap (debug/verif)

Behaviour:
- Reset: slot_valid=0, slot_instr=0, slot_pc=0, pending=0, state=RUN. All outputs 0 except if_ready_o=1.
- States:
  - RUN: issuing.
  - WAIT_BR: branch issued, awaiting resolve.
  - FLUSH: one cycle, squash.
- Hazard: hz = slot_valid & (pend[rs1] | pend[rs2] | (dec_reg_w_i & pend[rd])).
  - Evaluated on the registered bitmap; no same-cycle writeback bypass, so release costs 1 extra cycle.
  - pend[0] is forced 0.
- ex_valid_o = (state==RUN) & slot_valid & !hz. fire = ex_valid_o & ex_ready_i.
- ex_valid_o and slot contents stay stable until fire; they are never withdrawn while in RUN.
- stall_o = (state==RUN) & slot_valid & hz.
- if_ready_o = (state==RUN) & (!slot_valid | fire). Accept = if_valid_i & if_ready_o loads the slot.
- Back-to-back issue is supported: an instruction accepted at cycle N can issue at N+1, so throughput is 1/cycle absent hazards.
- On fire with dec_reg_w_i & rd!=0, set pend[rd].
- On wb_valid_i & wb_rd_i!=0, clear pend[wb_rd_i]. If set and clear target the same register in the same cycle, set wins.
- On fire with dec_is_branch_i: go to WAIT_BR. The slot may still be refilled in that same cycle.
- WAIT_BR:
  - No issue; if_ready_o=0.
  - br_resolve_i & !br_taken_i -> RUN, slot kept.
  - br_resolve_i & br_taken_i -> FLUSH.
- FLUSH: flush_o=1 for exactly one cycle; slot_valid cleared; if_ready_o=0; next state RUN.
- br_resolve_i outside WAIT_BR is ignored.
- The scoreboard is not cleared by a flush; older instructions still write back.
- rst mid-operation: everything returns to reset values next edge, including during WAIT_BR/FLUSH. flush_o is not asserted by reset.
- dec_instr_o = slot_valid ? slot_instr : 0. A 0 instruction decodes to the decoder's default (no write, no branch).

Decomposition:
- Shared package/DEFINITIONS.v additions:
  - ISSUE_STATE_WIDTH=2.
  - Encodings ISSUE_RUN=0, ISSUE_WAIT_BR=1, ISSUE_FLUSH=2.
  - Reuse `API_DATA_WIDTH and `API_REGISTER_ADDR_WIDTH.
- Sub-module rv32_scoreboard:
  - Inputs: set_en/set_addr, clr_en/clr_addr, three read addrs.
  - Outputs: three busy bits and the bitmap.
  - Encapsulates set-wins priority and the x0 masking.

Test Plan:
- Reset/idle: rst=1 two cycles, then stream ADD x1,x2,x3 with ex_ready=1 -> ex_valid at N+1, pend[1]=1, pending_o=0x00000002.
- RAW stall: issue ADD x5 then ADD x6,x5,x5; no wb for 4 cycles -> stall_o=1 for 4 cycles. wb_rd=5 -> stall_o=0, issue on the following cycle.
- Set/clear collision: wb_valid, wb_rd=7 in the same cycle as issue of ADDI x7 -> pend[7] stays 1. Also wb_rd=0 and rd=x0 writes never set bit 0.
- Backpressure: ex_ready=0 for 3 cycles with slot full -> ex_valid held, ex_pc_o stable, if_ready_o=0. Release -> one issue, slot refilled the same cycle.
- Taken branch: BEQ issued with next instruction in the slot; 3 cycles later br_resolve=1, taken=1 -> exactly one flush_o pulse, slot squashed (no ex_valid for it), if_ready_o=1 the cycle after.
- Not-taken and reset-in-WAIT_BR:
  - resolve with taken=0 -> slot instruction issues the next cycle, flush_o=0.
  - Separately, rst during WAIT_BR -> state RUN, pending_o=0, flush_o=0.
